stat_counter_reader: RTL and testbench

STAT_COUNTER_READER -- requirements
Module: stat_counter_reader

---
 rtl/stat_counter_pkg.sv | 15 +
 rtl/stat_counter_reader.sv | 110 +++++++++++
 tb/tb_stat_counter_reader.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stat_counter_pkg.sv
// Shared types and constants for the statistics counter CSR reader.
// FSM encoding and response word width live here.
package stat_counter_pkg;

  localparam int RESP_W = 32;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_ACK,
    S_RESP,
    S_FLUSH
  } state_t;

endpackage

// File: rtl/stat_counter_reader.sv
// CSR front end for a read-clear 64-bit counter table.
// Low-word reads clear the entry and latch a shadow; high-word reads return it.
module stat_counter_reader
  import stat_counter_pkg::*;
#(
  parameter int INDEX_WIDTH    = 10,
  parameter int COUNTER_WIDTH  = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [INDEX_WIDTH-1:0]   req_index,
  input  logic                     req_hi,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [RESP_W-1:0]        resp_data,
  output logic                     resp_err,
  input  logic                     init_done,
  output logic                     rdreq_valid,
  output logic [INDEX_WIDTH-1:0]   rdreq_index,
  input  logic                     rdack_valid,
  input  logic [COUNTER_WIDTH-1:0] rdack_value
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  state_t state, state_n;

  logic [TW-1:0]            tcnt;
  logic [COUNTER_WIDTH-1:0] shadow;
  logic                     timed_out;
  logic                     accept;
  logic                     tc_hit;

  assign accept = req_valid & req_ready;
  assign tc_hit = (tcnt == TLAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE:
        if (accept) state_n = req_hi ? S_RESP : S_ISSUE;
      S_ISSUE:
        state_n = S_WAIT_ACK;
      S_WAIT_ACK:
        if (rdack_valid || tc_hit) state_n = S_RESP;
      S_RESP:
        if (resp_ready) state_n = timed_out ? S_FLUSH : S_IDLE;
      S_FLUSH:
        if (tc_hit) state_n = S_IDLE;
      default:
        state_n = S_IDLE;
    endcase
  end

  // rstn gate keeps req_ready low while reset is held
  always_comb begin
    req_ready   = rstn & init_done & (state == S_IDLE);
    resp_valid  = (state == S_RESP);
    rdreq_valid = (state == S_ISSUE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdreq_index <= '0;
      resp_data   <= '0;
      resp_err    <= 1'b0;
      shadow      <= '0;
      tcnt        <= '0;
      timed_out   <= 1'b0;
    end else begin
      if (accept) begin
        rdreq_index <= req_index;
        timed_out   <= 1'b0;
        if (req_hi) begin
          resp_data <= shadow[COUNTER_WIDTH-1:RESP_W];
          resp_err  <= 1'b0;
        end
      end
      if (state == S_WAIT_ACK) begin
        if (rdack_valid) begin
          shadow    <= rdack_value;
          resp_data <= rdack_value[RESP_W-1:0];
          resp_err  <= 1'b0;
          tcnt      <= '0;
        end else if (tc_hit) begin
          resp_data <= '0;
          resp_err  <= 1'b1;
          timed_out <= 1'b1;
          tcnt      <= '0;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
      end else if (state == S_FLUSH) begin
        tcnt <= tc_hit ? '0 : tcnt + 1'b1;
      end else begin
        tcnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stat_counter_reader.sv
// Directed bench for stat_counter_reader with an 8-cycle timeout.
// Expected values are hand-computed constants.
module tb_stat_counter_reader;

  localparam int IW = 10;
  localparam int CW = 64;
  localparam int TO = 8;

  logic          clk;
  logic          rstn;
  logic          req_valid;
  logic          req_ready;
  logic [IW-1:0] req_index;
  logic          req_hi;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_data;
  logic          resp_err;
  logic          init_done;
  logic          rdreq_valid;
  logic [IW-1:0] rdreq_index;
  logic          rdack_valid;
  logic [CW-1:0] rdack_value;

  int total = 0;
  int bad   = 0;

  stat_counter_reader #(
    .INDEX_WIDTH   (IW),
    .COUNTER_WIDTH (CW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_index   (req_index),
    .req_hi      (req_hi),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_data   (resp_data),
    .resp_err    (resp_err),
    .init_done   (init_done),
    .rdreq_valid (rdreq_valid),
    .rdreq_index (rdreq_index),
    .rdack_valid (rdack_valid),
    .rdack_value (rdack_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn        = 1'b0;
    req_valid   = 1'b0;
    req_index   = '0;
    req_hi      = 1'b0;
    resp_ready  = 1'b0;
    init_done   = 1'b0;
    rdack_valid = 1'b0;
    rdack_value = '0;

    // reset state
    tick();
    init_done = 1'b1;
    #1;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data", resp_data, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_rdreq_valid", 32'(rdreq_valid), 32'd0);
    chk("rst_rdreq_index", 32'(rdreq_index), 32'd0);
    init_done = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    // request blocked until init_done
    req_valid = 1'b1;
    req_index = 10'd5;
    req_hi    = 1'b0;
    #1;
    chk("noinit_ready", 32'(req_ready), 32'd0);
    tick();
    chk("noinit_rdreq", 32'(rdreq_valid), 32'd0);
    init_done = 1'b1;
    #1;
    chk("init_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    #1;
    chk("lo_rdreq_valid", 32'(rdreq_valid), 32'd1);
    chk("lo_rdreq_index", 32'(rdreq_index), 32'd5);
    tick();
    chk("lo_rdreq_pulse", 32'(rdreq_valid), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lo_wait_novalid", 32'(resp_valid), 32'd0);
    end
    rdack_valid = 1'b1;
    rdack_value = 64'h0000_0012_3456_789A;
    tick();
    rdack_valid = 1'b0;
    rdack_value = '0;
    #1;
    chk("lo_resp_valid", 32'(resp_valid), 32'd1);
    chk("lo_resp_data", resp_data, 32'h3456_789A);
    chk("lo_resp_err", 32'(resp_err), 32'd0);

    // backpressure hold
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("hold_valid", 32'(resp_valid), 32'd1);
      chk("hold_data", resp_data, 32'h3456_789A);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    chk("lo_done_valid", 32'(resp_valid), 32'd0);
    chk("lo_done_ready", 32'(req_ready), 32'd1);

    // high word from shadow
    req_valid = 1'b1;
    req_hi    = 1'b1;
    tick();
    req_valid = 1'b0;
    req_hi    = 1'b0;
    #1;
    chk("hi_resp_valid", 32'(resp_valid), 32'd1);
    chk("hi_resp_data", resp_data, 32'h0000_0012);
    chk("hi_resp_err", 32'(resp_err), 32'd0);
    chk("hi_no_rdreq", 32'(rdreq_valid), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // spurious rdack in IDLE
    rdack_valid = 1'b1;
    rdack_value = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    tick();
    rdack_valid = 1'b0;
    rdack_value = '0;
    #1;
    chk("spur_no_valid", 32'(resp_valid), 32'd0);
    req_valid = 1'b1;
    req_hi    = 1'b1;
    tick();
    req_valid = 1'b0;
    req_hi    = 1'b0;
    #1;
    chk("spur_shadow", resp_data, 32'h0000_0012);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // timeout then flush
    req_valid = 1'b1;
    req_index = 10'd7;
    tick();
    req_valid = 1'b0;
    tick();
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      chk("to_wait_novalid", 32'(resp_valid), 32'd0);
    end
    tick();
    chk("to_resp_valid", 32'(resp_valid), 32'd1);
    chk("to_resp_err", 32'(resp_err), 32'd1);
    chk("to_resp_data", resp_data, 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    for (int i = 0; i < TO - 1; i++) begin
      rdack_valid = (i == 0);
      rdack_value = 64'hAAAA_BBBB_CCCC_DDDD;
      tick();
      chk("flush_req_ready", 32'(req_ready), 32'd0);
      chk("flush_no_valid", 32'(resp_valid), 32'd0);
    end
    rdack_valid = 1'b0;
    rdack_value = '0;
    tick();
    chk("flush_exit_ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_hi    = 1'b1;
    tick();
    req_valid = 1'b0;
    req_hi    = 1'b0;
    #1;
    chk("flush_shadow", resp_data, 32'h0000_0012);
    chk("flush_hi_err", 32'(resp_err), 32'd0);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;

    // init_done drop mid-transaction
    req_valid = 1'b1;
    req_index = 10'd3;
    tick();
    req_valid = 1'b0;
    init_done = 1'b0;
    #1;
    chk("drop_rdreq_index", 32'(rdreq_index), 32'd3);
    tick();
    rdack_valid = 1'b1;
    rdack_value = 64'h0000_0001_0000_0002;
    tick();
    rdack_valid = 1'b0;
    rdack_value = '0;
    #1;
    chk("drop_resp_valid", 32'(resp_valid), 32'd1);
    chk("drop_resp_data", resp_data, 32'd2);
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    #1;
    chk("drop_gated", 32'(req_ready), 32'd0);
    init_done = 1'b1;

    // reset in WAIT_ACK
    req_valid = 1'b1;
    req_index = 10'd9;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rstn = 1'b0;
    #1;
    chk("mrst_req_ready", 32'(req_ready), 32'd0);
    chk("mrst_rdreq_index", 32'(rdreq_index), 32'd0);
    chk("mrst_resp_data", resp_data, 32'd0);
    chk("mrst_rdreq_valid", 32'(rdreq_valid), 32'd0);
    tick();
    rstn = 1'b1;
    tick();
    rdack_valid = 1'b1;
    rdack_value = 64'h5555_6666_7777_8888;
    tick();
    rdack_valid = 1'b0;
    rdack_value = '0;
    #1;
    chk("mrst_no_resp", 32'(resp_valid), 32'd0);
    tick();
    chk("mrst_still_idle", 32'(resp_valid), 32'd0);
    req_valid = 1'b1;
    req_hi    = 1'b1;
    tick();
    req_valid = 1'b0;
    req_hi    = 1'b0;
    #1;
    chk("mrst_hi_data", resp_data, 32'd0);
    chk("mrst_hi_err", 32'(resp_err), 32'd0);
    chk("mrst_hi_valid", 32'(resp_valid), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
